// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions for an external PC counter and issues them downstream.
// Decodes JMP/BR/HALT on the issue handshake to steer the PC (load, relative step, or increment).
module fetch_sequencer (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic signed [15:0] pc_value_i,
  output logic               mem_req_o,
  output logic        [15:0] mem_addr_o,
  input  logic               mem_ready_i,
  input  logic               mem_valid_i,
  input  logic        [15:0] mem_data_i,
  output logic               load_enable_o,
  output logic signed [15:0] load_value_o,
  output logic               offset_enable_o,
  output logic signed [8:0]  offset_o,
  output logic        [15:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               halted_o,
  output logic        [15:0] retired_count_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ISSUE, HALT} state_e;
  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] retired_q, retired_d;
  logic        hs, is_jmp, is_br, is_halt;
  assign hs      = state_q == ISSUE && instr_ready_i;
  assign is_jmp  = instr_q[15:12] == 4'hC;
  assign is_br   = instr_q[15:12] == 4'hD;
  assign is_halt = instr_q[15:12] == 4'hF;
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      addr_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = mem_ready_i ? WAIT : REQ;
      WAIT:    state_d = mem_valid_i ? ISSUE : WAIT;
      ISSUE:   state_d = !hs ? ISSUE : is_halt ? HALT : REQ;
      default: state_d = HALT;
    endcase
    instr_d   = (state_q == WAIT && mem_valid_i) ? mem_data_i : instr_q;
    addr_d    = (state_q == REQ && mem_ready_i) ? pc_value_i : addr_q;
    retired_d = retired_q + {15'd0, hs};
  end
  // Everything is held at zero while reset is asserted so the counter and memory see a quiet bus.
  always_comb begin
    mem_req_o       = rst_ni && state_q == REQ;
    mem_addr_o      = !rst_ni ? 16'd0 : state_q == REQ ? pc_value_i : addr_q;
    load_enable_o   = rst_ni && (!hs || is_jmp || is_halt);
    load_value_o    = !rst_ni ? 16'sd0 : (hs && is_jmp) ? $signed({4'd0, instr_q[11:0]}) : pc_value_i;
    offset_enable_o = rst_ni && hs && is_br;
    offset_o        = (rst_ni && hs && is_br) ? $signed(instr_q[8:0]) : 9'sd0;
    instr_o         = instr_q;
    instr_valid_o   = rst_ni && state_q == ISSUE;
    halted_o        = rst_ni && state_q == HALT;
    retired_count_o = retired_q;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with the ports listed below (clock and reset first).
REQ-002 Clock  in  1  rising-edge system clock.
REQ-003 ResetN  in  1  synchronous, active-low reset.
REQ-004 PcValue  in  16 signed  current program-counter value.
REQ-005 MemReq  out  1  instruction-memory read request.
REQ-006 MemAddr  out  16  read address.
REQ-007 MemReady  in  1  request accepted this cycle.
REQ-008 MemValid  in  1  read data valid.
REQ-009 MemData  in  16  read data.
REQ-010 LoadEnable  out  1  PC load strobe.
REQ-011 LoadValue  out  16 signed  PC load value.
REQ-012 OffsetEnable  out  1  PC relative-step strobe.
REQ-013 Offset  out  9 signed  PC relative step.
REQ-014 Instr  out  16  fetched instruction.
REQ-015 InstrValid  out  1  Instr valid.
REQ-016 InstrReady  in  1  downstream accepts Instr.
REQ-017 Halted  out  1  HALT executed.
REQ-018 RetiredCount  out  16  count of accepted instructions.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, ISSUE, HALT.
REQ-020 Opcode = Instr[15:12]: 4'hC JMP (target = zero-extended Instr[11:0]), 4'hD BR (signed step Instr[8:0]), 4'hF HALT, all others sequential.
REQ-021 Default PC hold, in every cycle except an ISSUE handshake cycle: LoadEnable=1, LoadValue=PcValue, OffsetEnable=0.
REQ-022 IDLE: lasts exactly one cycle after reset release, then moves to REQ.
REQ-023 REQ: MemReq=1 and MemAddr=PcValue.
REQ-024 REQ: on MemReady=1 the block SHALL latch PcValue and move to WAIT.
REQ-025 REQ: MemAddr SHALL remain stable while MemReady=0.
REQ-026 WAIT: MemReq=0; on MemValid=1 the block SHALL register MemData into Instr and move to ISSUE.
REQ-027 Minimum request-to-ISSUE latency SHALL be 2 cycles.
REQ-028 MemValid SHALL be ignored outside WAIT, including when it coincides with MemReady in REQ.
REQ-029 ISSUE: InstrValid=1; Instr SHALL remain stable until InstrValid && InstrReady.
REQ-030 On an ISSUE handshake with a sequential opcode: LoadEnable=0 and OffsetEnable=0, so the PC increments by 1.
REQ-031 On an ISSUE handshake with JMP: LoadEnable=1, LoadValue=target.
REQ-032 On an ISSUE handshake with BR: LoadEnable=0, OffsetEnable=1, Offset=Instr[8:0] (range -256..+255, relative to the current PcValue).
REQ-033 After a sequential, JMP or BR handshake the next state SHALL be REQ; the PC updates on the same edge, so REQ sees the new PcValue.
REQ-034 On an ISSUE handshake with HALT: the PC is held and the next state is HALT.
REQ-035 HALT: InstrValid=0, MemReq=0, PC held, Halted=1; exit only by reset.
REQ-036 RetiredCount SHALL increment by 1 on every ISSUE handshake (HALT included) and wrap 16'hFFFF->0.
REQ-037 PC address wrap-around SHALL be left to the counter; the block applies no saturation.
REQ-038 LoadEnable and OffsetEnable SHALL never both be 1 in the same cycle.

Reset
REQ-039 While ResetN=0 at a rising edge: state=IDLE, Instr=0, InstrValid=0, MemReq=0, MemAddr=0, Halted=0, RetiredCount=0, LoadEnable=0, OffsetEnable=0, LoadValue=0, Offset=0.
REQ-040 Reset in any state, including WAIT with a read outstanding, SHALL abandon the fetch; the memory is reset on the same ResetN.

Verification
REQ-041 Reset release with PcValue=0, MemReady=1, MemValid one cycle later, MemData=16'h1234, InstrReady=1 -> MemReq at cycle 2, InstrValid=1 with Instr=16'h1234, PC increments to 1, RetiredCount=1.
REQ-042 PcValue=16'h0010, MemData=16'hC0AB -> LoadEnable=1, LoadValue=16'h00AB on the handshake; next MemAddr=16'h00AB.
REQ-043 PcValue=16'h0010, MemData=16'hD1F0 (Offset=-16) -> OffsetEnable=1, Offset=-16; next MemAddr=16'h0000. Repeat with a PcValue=16'hFFF8, +16 step -> next MemAddr=16'h0008.
REQ-044 InstrReady held 0 for 5 cycles in ISSUE -> Instr stable, LoadEnable=1, LoadValue=PcValue throughout, RetiredCount unchanged.
REQ-045 MemData=16'hF000 -> Halted=1, MemReq stays 0 for 20 cycles; ResetN=0 pulse -> IDLE, Halted=0, RetiredCount=0.
REQ-046 ResetN=0 asserted in WAIT, then MemValid=1 while in reset -> no Instr capture, RetiredCount=0; normal fetch resumes after release.
